alu_issue_stage: RTL and testbench

Registered issue stage directly upstream of the 32-bit ALU. Accepts one decoded instruction per cycle over a valid/ready handshake, maps opcode/funct to the ALU's 6-bit `Signal` code, and selects and extends operands. Drives the ALU's `dataA`/`dataB`/`Signal` from registers. A 2-entry skid buffer absorbs downstream stalls without combinational ready paths.

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_issue_decode.sv | 53 +++++
 rtl/alu_issue_stage.sv | 138 +++++++++++++
 tb/tb_alu_issue_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU Signal codes, opcode/funct values,
// the issued-op record and the skid-buffer state encoding.
package alu_pkg;

    localparam logic [5:0] SIG_ADD = 6'd32;
    localparam logic [5:0] SIG_SUB = 6'd34;
    localparam logic [5:0] SIG_AND = 6'd36;
    localparam logic [5:0] SIG_OR  = 6'd37;
    localparam logic [5:0] SIG_SLT = 6'd42;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_ADDU = 6'd33;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_SUBU = 6'd35;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_SLT  = 6'd42;

    // The issued-op record is sized from this width; the top's DEST_W must match it.
    localparam int ISSUE_DEST_W = 5;

    typedef struct packed {
        logic [31:0]             dataA;
        logic [31:0]             dataB;
        logic [5:0]              sig;
        logic [ISSUE_DEST_W-1:0] dest;
        logic                    illegal;
    } issue_op_t;

    localparam issue_op_t OP_RESET = '{dataA: 32'd0, dataB: 32'd0, sig: SIG_ADD,
                                       dest: '0, illegal: 1'b0};

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} skid_state_t;

    function automatic logic [31:0] extendImm(input logic [15:0] imm, input logic signExt);
        return signExt ? {{16{imm[15]}}, imm} : {16'd0, imm};
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational opcode/funct decode into the ALU Signal code and operand-B selection.
// Unsupported encodings decode as an illegal ADD so they can still be issued.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [5:0] o_signal,
    output logic       o_immSel,
    output logic       o_signExt,
    output logic       o_illegal
);

    always_comb begin
        o_signal  = SIG_ADD;
        o_immSel  = 1'b0;
        o_signExt = 1'b0;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADD, FN_ADDU: o_signal = SIG_ADD;
                    FN_SUB, FN_SUBU: o_signal = SIG_SUB;
                    FN_AND:          o_signal = SIG_AND;
                    FN_OR:           o_signal = SIG_OR;
                    FN_SLT:          o_signal = SIG_SLT;
                    default:         o_illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
                o_signal  = SIG_ADD;
                o_immSel  = 1'b1;
                o_signExt = 1'b1;
            end
            OP_SLTI: begin
                o_signal  = SIG_SLT;
                o_immSel  = 1'b1;
                o_signExt = 1'b1;
            end
            OP_ANDI: begin
                o_signal = SIG_AND;
                o_immSel = 1'b1;
            end
            OP_ORI: begin
                o_signal = SIG_OR;
                o_immSel = 1'b1;
            end
            OP_BEQ, OP_BNE: o_signal = SIG_SUB;
            default:        o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered issue stage in front of the 32-bit ALU with a 2-entry skid buffer.
// Define ALU_ISSUE_FWD_EN to add the fwd_* bypass port on the source operands.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DEST_W = ISSUE_DEST_W
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [DEST_W-1:0] rs_idx,
    input  logic [DEST_W-1:0] rt_idx,
    input  logic [31:0]       rs_data,
    input  logic [31:0]       rt_data,
    input  logic [15:0]       imm16,
    input  logic [DEST_W-1:0] dest_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       dataA,
    output logic [31:0]       dataB,
    output logic [5:0]        Signal,
    output logic [DEST_W-1:0] dest_out,
    output logic              illegal
`ifdef ALU_ISSUE_FWD_EN
    ,
    input  logic              fwd_valid,
    input  logic [DEST_W-1:0] fwd_idx,
    input  logic [31:0]       fwd_data
`endif
);

    logic [5:0]  w_decSignal;
    logic        w_decImmSel;
    logic        w_decSignExt;
    logic        w_decIllegal;
    logic [31:0] w_rsVal;
    logic [31:0] w_rtVal;
    issue_op_t   w_newOp;
    logic        w_inXfer;
    logic        w_outXfer;

    skid_state_t r_state;
    issue_op_t   r_out;
    issue_op_t   r_skid;
    logic        r_outValid;
    logic        r_inReady;

    alu_issue_decode u_decode (
        .i_opcode  (opcode),
        .i_funct   (funct),
        .o_signal  (w_decSignal),
        .o_immSel  (w_decImmSel),
        .o_signExt (w_decSignExt),
        .o_illegal (w_decIllegal)
    );

    // Register index 0 reads as zero even if a bypass targets it.
    always_comb begin
        w_rsVal = rs_data;
        w_rtVal = rt_data;
`ifdef ALU_ISSUE_FWD_EN
        if (fwd_valid && fwd_idx == rs_idx) w_rsVal = fwd_data;
        if (fwd_valid && fwd_idx == rt_idx) w_rtVal = fwd_data;
`endif
        if (rs_idx == '0) w_rsVal = 32'd0;
        if (rt_idx == '0) w_rtVal = 32'd0;

        w_newOp.dataA   = w_rsVal;
        w_newOp.dataB   = w_decImmSel ? extendImm(imm16, w_decSignExt) : w_rtVal;
        w_newOp.sig     = w_decSignal;
        w_newOp.dest    = dest_in;
        w_newOp.illegal = w_decIllegal;
        if (w_decIllegal) begin
            w_newOp.dataA = 32'd0;
            w_newOp.dataB = 32'd0;
        end
    end

    assign w_inXfer  = in_valid && r_inReady;
    assign w_outXfer = r_outValid && out_ready;

    // SKID only fills when OUT is stalled, and always drains back into OUT, so order holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_out      <= OP_RESET;
            r_skid     <= OP_RESET;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_inXfer) begin
                        r_out      <= w_newOp;
                        r_outValid <= 1'b1;
                        r_state    <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_inXfer && w_outXfer) begin
                        r_out <= w_newOp;
                    end else if (w_inXfer) begin
                        r_skid    <= w_newOp;
                        r_inReady <= 1'b0;
                        r_state   <= ST_TWO;
                    end else if (w_outXfer) begin
                        r_outValid <= 1'b0;
                        r_state    <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_outXfer) begin
                        r_out     <= r_skid;
                        r_inReady <= 1'b1;
                        r_state   <= ST_ONE;
                    end
                end
                default: begin
                    r_outValid <= 1'b0;
                    r_inReady  <= 1'b1;
                    r_state    <= ST_EMPTY;
                end
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign dataA     = r_out.dataA;
    assign dataB     = r_out.dataB;
    assign Signal    = r_out.sig;
    assign dest_out  = r_out.dest;
    assign illegal   = r_out.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: decode vector table plus stall, reset
// and (when ALU_ISSUE_FWD_EN is defined) forwarding sequences.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [15:0] imm16;
    logic [4:0]  dest_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [4:0]  dest_out;
    logic        illegal;
`ifdef ALU_ISSUE_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_idx;
    logic [31:0] fwd_data;
`endif

    int checksTotal  = 0;
    int checksPassed = 0;

    typedef struct {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rsIdx;
        logic [4:0]  rtIdx;
        logic [31:0] rsData;
        logic [31:0] rtData;
        logic [15:0] imm;
        logic [4:0]  dest;
        logic [5:0]  expSig;
        logic [31:0] expA;
        logic [31:0] expB;
        logic        expIll;
    } vec_t;

    localparam int NUM_VECS = 14;
    vec_t vecs [NUM_VECS];

    always #5 clk = ~clk;

    alu_issue_stage #(.DEST_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .funct     (funct),
        .rs_idx    (rs_idx),
        .rt_idx    (rt_idx),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .imm16     (imm16),
        .dest_in   (dest_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dataA     (dataA),
        .dataB     (dataB),
        .Signal    (Signal),
        .dest_out  (dest_out),
        .illegal   (illegal)
`ifdef ALU_ISSUE_FWD_EN
        ,
        .fwd_valid (fwd_valid),
        .fwd_idx   (fwd_idx),
        .fwd_data  (fwd_data)
`endif
    );

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checksTotal++;
        if (act !== exp)
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        else
            checksPassed++;
    endtask

    task automatic driveInputs(input vec_t v);
        opcode  = v.opcode;
        funct   = v.funct;
        rs_idx  = v.rsIdx;
        rt_idx  = v.rtIdx;
        rs_data = v.rsData;
        rt_data = v.rtData;
        imm16   = v.imm;
        dest_in = v.dest;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        driveInputs(v);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        checkVal({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        checkVal({tag, ".Signal"},    32'(Signal),    32'(v.expSig));
        checkVal({tag, ".dataA"},     dataA,          v.expA);
        checkVal({tag, ".dataB"},     dataB,          v.expB);
        checkVal({tag, ".dest_out"},  32'(dest_out),  32'(v.dest));
        checkVal({tag, ".illegal"},   32'(illegal),   32'(v.expIll));
    endtask

    initial begin
        //          opc    fn     rs  rt  rsData        rtData        imm       dst  sig  expA          expB          ill
        vecs[0]  = '{6'd0,  6'd32, 5'd1, 5'd2, 32'd5,        32'd7,        16'h0000, 5'd3,  6'd32, 32'd5,        32'd7,        1'b0};
        vecs[1]  = '{6'd12, 6'd0,  5'd3, 5'd4, 32'hFFFFFFFF, 32'd0,        16'h8001, 5'd4,  6'd36, 32'hFFFFFFFF, 32'h00008001, 1'b0};
        vecs[2]  = '{6'd8,  6'd0,  5'd3, 5'd4, 32'd16,       32'd0,        16'h8001, 5'd5,  6'd32, 32'd16,       32'hFFFF8001, 1'b0};
        vecs[3]  = '{6'd0,  6'd43, 5'd1, 5'd2, 32'd11,       32'd22,       16'h0000, 5'd6,  6'd32, 32'd0,        32'd0,        1'b1};
        vecs[4]  = '{6'd0,  6'd32, 5'd0, 5'd4, 32'h1234,     32'd9,        16'h0000, 5'd7,  6'd32, 32'd0,        32'd9,        1'b0};
        vecs[5]  = '{6'd0,  6'd34, 5'd6, 5'd7, 32'd100,      32'd30,       16'h0000, 5'd8,  6'd34, 32'd100,      32'd30,       1'b0};
        vecs[6]  = '{6'd0,  6'd37, 5'd6, 5'd7, 32'hF0,       32'h0F,       16'h0000, 5'd9,  6'd37, 32'hF0,       32'h0F,       1'b0};
        vecs[7]  = '{6'd10, 6'd0,  5'd8, 5'd9, 32'd3,        32'd0,        16'hFFFF, 5'd10, 6'd42, 32'd3,        32'hFFFFFFFF, 1'b0};
        vecs[8]  = '{6'd13, 6'd0,  5'd8, 5'd9, 32'h1,        32'd0,        16'hF0F0, 5'd11, 6'd37, 32'h1,        32'h0000F0F0, 1'b0};
        vecs[9]  = '{6'd35, 6'd0,  5'd8, 5'd9, 32'h1000,     32'd0,        16'hFFFC, 5'd12, 6'd32, 32'h1000,     32'hFFFFFFFC, 1'b0};
        vecs[10] = '{6'd4,  6'd0,  5'd8, 5'd0, 32'h55,       32'h77,       16'h0010, 5'd13, 6'd34, 32'h55,       32'd0,        1'b0};
        vecs[11] = '{6'd2,  6'd0,  5'd8, 5'd9, 32'h55,       32'h77,       16'h0010, 5'd14, 6'd32, 32'd0,        32'd0,        1'b1};
        vecs[12] = '{6'd0,  6'd42, 5'd1, 5'd2, 32'hFFFFFFFE, 32'd4,        16'h0000, 5'd15, 6'd42, 32'hFFFFFFFE, 32'd4,        1'b0};
        vecs[13] = '{6'd0,  6'd33, 5'd31,5'd30,32'hDEADBEEF, 32'h12345678, 16'h0000, 5'd31, 6'd32, 32'hDEADBEEF, 32'h12345678, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        driveInputs(vecs[0]);
`ifdef ALU_ISSUE_FWD_EN
        fwd_valid = 1'b0;
        fwd_idx   = 5'd0;
        fwd_data  = 32'd0;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst.out_valid", 32'(out_valid), 32'd0);
        checkVal("rst.in_ready",  32'(in_ready),  32'd1);
        checkVal("rst.dataA",     dataA,          32'd0);
        checkVal("rst.dataB",     dataB,          32'd0);
        checkVal("rst.Signal",    32'(Signal),    32'd32);
        checkVal("rst.dest_out",  32'(dest_out),  32'd0);
        checkVal("rst.illegal",   32'(illegal),   32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back decode vectors at full throughput
        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i]);
            checkVal($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
        end

        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkVal("drain.out_valid", 32'(out_valid), 32'd0);

        // Stall with A, B, C back to back; C must wait upstream
        @(negedge clk);
        out_ready = 1'b0;
        driveInputs(vecs[0]);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("stallA", vecs[0]);
        checkVal("stallA.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        driveInputs(vecs[5]);
        @(posedge clk);
        #1;
        checkOutput("stallB.holdA", vecs[0]);
        checkVal("stallB.in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        driveInputs(vecs[6]);
        @(posedge clk);
        #1;
        checkOutput("stallC.holdA", vecs[0]);
        checkVal("stallC.in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("releaseB", vecs[5]);
        checkVal("releaseB.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("releaseC", vecs[6]);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkVal("releaseEnd.out_valid", 32'(out_valid), 32'd0);

        // Reset while both entries are full
        @(negedge clk);
        out_ready = 1'b0;
        driveInputs(vecs[1]);
        in_valid = 1'b1;
        @(negedge clk);
        driveInputs(vecs[2]);
        @(posedge clk);
        #1;
        checkVal("two.in_ready", 32'(in_ready), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        checkVal("midRst.out_valid", 32'(out_valid), 32'd0);
        checkVal("midRst.in_ready",  32'(in_ready),  32'd1);
        checkVal("midRst.Signal",    32'(Signal),    32'd32);
        checkVal("midRst.dataA",     dataA,          32'd0);
        @(negedge clk);
        in_valid  = 1'b0;
        reset     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(vecs[7]);
        checkOutput("afterRst", vecs[7]);

`ifdef ALU_ISSUE_FWD_EN
        begin
            vec_t fv;
            fv = '{6'd0, 6'd32, 5'd3, 5'd4, 32'h11, 32'd2, 16'h0, 5'd1, 6'd32, 32'hAA, 32'd2, 1'b0};
            fwd_valid = 1'b1;
            fwd_idx   = 5'd3;
            fwd_data  = 32'hAA;
            applyStimulus(fv);
            checkOutput("fwdRs", fv);
            fv = '{6'd0, 6'd32, 5'd0, 5'd4, 32'h11, 32'd2, 16'h0, 5'd1, 6'd32, 32'd0, 32'd2, 1'b0};
            fwd_idx = 5'd0;
            applyStimulus(fv);
            checkOutput("fwdZero", fv);
            fv = '{6'd8, 6'd0, 5'd5, 5'd3, 32'h20, 32'h99, 16'h0004, 5'd2, 6'd32, 32'h20, 32'd4, 1'b0};
            fwd_idx = 5'd3;
            applyStimulus(fv);
            checkOutput("fwdImmB", fv);
            fwd_valid = 1'b0;
        end
`endif

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
